// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^8) constants, op codes, pass counts, coefficients, FSM state and helpers
package gf_pkg;
   localparam logic [8:0] RED_POLY = 9'h11B;
   localparam logic [2:0] OP_MIXCOL = 3'd0;
   localparam logic [2:0] OP_INVMIX = 3'd1;
   localparam logic [2:0] OP_INV    = 3'd2;
   localparam logic [2:0] OP_MUL    = 3'd3;
   localparam logic [3:0] NP_MIXCOL = 4'd2;
   localparam logic [3:0] NP_INVMIX = 4'd4;
   localparam logic [3:0] NP_INV    = 4'd13;
   localparam logic [3:0] NP_MUL    = 4'd1;
   localparam logic [1:0][7:0] MIX_COEF = {8'h03, 8'h02};
   localparam logic [3:0][7:0] INV_COEF = {8'h09, 8'h0D, 8'h0B, 8'h0E};
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   function automatic logic [3:0] pass_count(input logic [2:0] op);
      return op == OP_MIXCOL ? NP_MIXCOL :
             op == OP_INVMIX ? NP_INVMIX :
             op == OP_INV    ? NP_INV    :
             op == OP_MUL    ? NP_MUL    : 4'd0;
   endfunction
   // lane i of the result takes lane (i+k) mod 4 of x
   function automatic logic [31:0] rot_lane(input logic [31:0] x, input logic [1:0] k);
      return k == 2'd0 ? x :
             k == 2'd1 ? {x[7:0], x[31:8]} :
             k == 2'd2 ? {x[15:0], x[31:16]} : {x[23:0], x[31:24]};
   endfunction
   function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = {x[6:0], 1'b0} ^ (x[7] ? RED_POLY[7:0] : 8'h00);
      end
      return p;
   endfunction
endpackage

// File: rtl/gf_mix_seq_if.sv
// gf_mix_seq_if: command/response handshake bundle of the GF mix sequencer
interface gf_mix_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;
   logic [2:0]  cmd_payload_state_id;
   logic [3:0]  cmd_payload_cxu_id;
   logic        cmd_payload_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;
   logic        rsp_payload_ready;
   modport master (
      output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
             cmd_payload_state_id, cmd_payload_cxu_id, cmd_payload_ready, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_payload_outputs_0, rsp_payload_ready
   );
   modport slave (
      input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
             cmd_payload_state_id, cmd_payload_cxu_id, cmd_payload_ready, rsp_ready,
      output cmd_ready, rsp_valid, rsp_payload_outputs_0, rsp_payload_ready
   );
endinterface

// File: rtl/gf_mul8x4.sv
// gf_mul8x4: combinational 4-lane GF(2^8) multiplier, lane i = byte i
module gf_mul8x4
   import gf_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_p
);
   for (genvar g = 0; g < 4; g++) begin : g_lane
      assign o_p[8*g +: 8] = gf_mul8(i_a[8*g +: 8], i_b[8*g +: 8]);
   end
endmodule

// File: rtl/gf_mix_seq.sv
// gf_mix_seq: multi-pass MixColumns / InvMixColumns / inverse / multiply on one shared GF multiplier
module gf_mix_seq
   import gf_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   gf_mix_seq_if.slave  io
);
   state_t      r_state;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_acc;
   logic [31:0] r_out;
   logic [2:0]  r_op;
   logic [3:0]  r_cnt;
   logic        r_cmd_ready;
   logic        r_rsp_valid;
   logic [3:0]  w_idx;
   logic [31:0] w_r;
   logic [7:0]  w_coef;
   logic [31:0] w_ma;
   logic [31:0] w_mb;
   logic [31:0] w_prod;
   logic [31:0] w_acc_nxt;
   logic [31:0] w_res;
   logic        w_unused;
   logic [3:0]  w_np;
   assign w_idx = pass_count(r_op) - r_cnt;
   assign w_np  = pass_count(io.cmd_payload_function_id);
   // INV keeps its running power in the accumulator; pass 0 starts from A
   assign w_r = (w_idx == 4'd0) ? r_a : r_acc;
   always_comb begin
      w_coef    = (r_op == OP_MIXCOL) ? MIX_COEF[w_idx[0]] : INV_COEF[w_idx[1:0]];
      w_ma      = (r_op == OP_INV) ? w_r : r_a;
      w_mb      = (r_op == OP_MUL) ? r_b : (r_op == OP_INV) ? (w_idx[0] ? r_a : w_r) : {4{w_coef}};
      w_acc_nxt = (r_op == OP_MIXCOL || r_op == OP_INVMIX) ? r_acc ^ rot_lane(w_prod, w_idx[1:0]) : w_prod;
      w_res     = (r_op == OP_MIXCOL) ? w_acc_nxt ^ rot_lane(r_a, 2'd2) ^ rot_lane(r_a, 2'd3) : w_acc_nxt;
   end
   gf_mul8x4 u_mul (.i_a(w_ma), .i_b(w_mb), .o_p(w_prod));
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_out       <= '0;
         r_op        <= '0;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (io.cmd_valid) begin
               r_a         <= io.cmd_payload_inputs_0;
               r_b         <= io.cmd_payload_inputs_1;
               r_op        <= io.cmd_payload_function_id;
               r_acc       <= '0;
               r_cnt       <= w_np;
               r_cmd_ready <= 1'b0;
               r_state     <= (w_np == 4'd0) ? RESP : BUSY;
               r_rsp_valid <= (w_np == 4'd0);
               r_out       <= (w_np == 4'd0) ? '0 : r_out;
            end
            BUSY: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_out       <= w_res;
               end
            end
            RESP: if (io.rsp_ready) begin
               r_state     <= IDLE;
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign io.cmd_ready             = r_cmd_ready;
   assign io.rsp_valid             = r_rsp_valid;
   assign io.rsp_payload_outputs_0 = r_out;
   assign io.rsp_payload_ready     = 1'b1;
   assign w_unused = ^{io.cmd_payload_state_id, io.cmd_payload_cxu_id, io.cmd_payload_ready};
endmodule

// File: tb/tb_gf_mix_seq.sv
// tb_gf_mix_seq: directed vectors, backpressure and mid-operation reset for gf_mix_seq
module tb_gf_mix_seq;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   gf_mix_seq_if bus();
   gf_mix_seq dut (.clk(clk), .reset(reset), .io(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;
   vec_t v [14];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic run_cmd(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
      int k;
      bus.rsp_ready = 1'b1;
      bus.cmd_payload_function_id = op;
      bus.cmd_payload_inputs_0 = a;
      bus.cmd_payload_inputs_1 = b;
      bus.cmd_payload_state_id = 3'($urandom);
      bus.cmd_payload_cxu_id = 4'($urandom);
      bus.cmd_payload_ready = 1'($urandom);
      bus.cmd_valid = 1'b1;
      chk({nm, " cmd_ready idle"}, 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk({nm, " cmd_ready after accept"}, 32'(bus.cmd_ready), 32'd0);
      k = 1;
      while (!bus.rsp_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({nm, " latency"}, 32'(k), 32'(lat));
      chk({nm, " result"}, bus.rsp_payload_outputs_0, exp);
      @(negedge clk);
      chk({nm, " rsp_valid after handshake"}, 32'(bus.rsp_valid), 32'd0);
      chk({nm, " cmd_ready after handshake"}, 32'(bus.cmd_ready), 32'd1);
   endtask
   initial begin
      v[0]  = '{3'd0, 32'h455313DB, 32'h0, 32'hBCA14D8E, 3};
      v[1]  = '{3'd1, 32'hBCA14D8E, 32'h0, 32'h455313DB, 5};
      v[2]  = '{3'd2, 32'h00010253, 32'h0, 32'h00018DCA, 14};
      v[3]  = '{3'd3, 32'h00000057, 32'h00000083, 32'h000000C1, 2};
      v[4]  = '{3'd5, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1};
      v[5]  = '{3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1};
      v[6]  = '{3'd7, 32'hDEADBEEF, 32'h01010101, 32'h00000000, 1};
      v[7]  = '{3'd0, 32'h5C220AF2, 32'h0, 32'h9D58DC9F, 3};
      v[8]  = '{3'd1, 32'h9D58DC9F, 32'h0, 32'h5C220AF2, 5};
      v[9]  = '{3'd0, 32'h01010101, 32'h0, 32'h01010101, 3};
      v[10] = '{3'd1, 32'h01010101, 32'h0, 32'h01010101, 5};
      v[11] = '{3'd3, 32'h02020202, 32'h80808080, 32'h1B1B1B1B, 2};
      v[12] = '{3'd3, 32'h53CA0102, 32'hCA530180, 32'h0101011B, 2};
      v[13] = '{3'd2, 32'h03020100, 32'h0, 32'hF68D0100, 14};
      bus.cmd_valid = 1'b0;
      bus.cmd_payload_function_id = '0;
      bus.cmd_payload_inputs_0 = '0;
      bus.cmd_payload_inputs_1 = '0;
      bus.cmd_payload_state_id = '0;
      bus.cmd_payload_cxu_id = '0;
      bus.cmd_payload_ready = 1'b0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset output", bus.rsp_payload_outputs_0, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("post-reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rsp_payload_ready", 32'(bus.rsp_payload_ready), 32'd1);
      for (int i = 0; i < 14; i++)
         run_cmd($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].exp, v[i].lat);
      // backpressure: response held while a second command waits on cmd_valid
      bus.rsp_ready = 1'b0;
      bus.cmd_payload_function_id = 3'd3;
      bus.cmd_payload_inputs_0 = 32'h02020202;
      bus.cmd_payload_inputs_1 = 32'h80808080;
      bus.cmd_valid = 1'b1;
      chk("bp cmd_ready idle", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      bus.cmd_payload_inputs_0 = 32'h00000057;
      bus.cmd_payload_inputs_1 = 32'h00000083;
      @(negedge clk);
      chk("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp first result", bus.rsp_payload_outputs_0, 32'h1B1B1B1B);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp hold%0d rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("bp hold%0d data", i), bus.rsp_payload_outputs_0, 32'h1B1B1B1B);
         chk($sformatf("bp hold%0d cmd_ready", i), 32'(bus.cmd_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp rsp_valid after handshake", 32'(bus.rsp_valid), 32'd0);
      chk("bp cmd_ready after handshake", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("bp second accepted", 32'(bus.cmd_ready), 32'd0);
      chk("bp second not early", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      chk("bp second rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp second result", bus.rsp_payload_outputs_0, 32'h000000C1);
      @(negedge clk);
      chk("bp second handshake", 32'(bus.rsp_valid), 32'd0);
      // reset during INV pass 6 with a nonzero previous result on the output
      bus.cmd_payload_function_id = 3'd2;
      bus.cmd_payload_inputs_0 = 32'h00010253;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("mid-op busy", 32'(bus.cmd_ready), 32'd0);
      #1 reset = 1'b0;
      #1;
      chk("async reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("async reset output", bus.rsp_payload_outputs_0, 32'd0);
      chk("async reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("release cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("release rsp_valid", 32'(bus.rsp_valid), 32'd0);
      run_cmd("post-reset mul", 3'd3, 32'h00000057, 32'h00000083, 32'h000000C1, 2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
